// File: rtl/fwupd_bufwr.sv
// Purpose: packs the command-path byte stream into 32-bit words for a 2-bank ping-pong BRAM.
//          A bank is handed to the reader (buf_done_o/buf_len_o) when it fills or is flushed.
// Latency: a word is written the cycle after its 4th byte is accepted; a flush closes the bank one cycle after flush_i.
// Backpressure: dat_ready_o is low for the FLUSH cycle and while the bank to be filled is still held by the reader.
//
// Ports:
//   clk_i, rstb_i           clock, asynchronous active-low reset
//   dat_i/dat_valid_i       input byte stream; dat_ready_o accepts it
//   flush_i                 single-cycle strobe, closes the current bank early
//   bram_we_o/addr_o/dat_o  BRAM write port, addr = {bank, word address}
//   buf_done_o/buf_len_o    per-bank close pulse with the word count of that bank
//   buf_free_i              per-bank strobe from the reader releasing a bank
//   cur_bank_o              bank currently being filled
`timescale 1ns/1ps

module fwupd_bufwr #(
  parameter int BUF_WORDS = 256,
  parameter bit LSB_FIRST = 1'b1,
  localparam int AW = $clog2(BUF_WORDS)
) (
  input  logic          clk_i,
  input  logic          rstb_i,
  input  logic [7:0]    dat_i,
  input  logic          dat_valid_i,
  output logic          dat_ready_o,
  input  logic          flush_i,
  output logic          bram_we_o,
  output logic [AW:0]   bram_addr_o,
  output logic [31:0]   bram_dat_o,
  output logic [1:0]    buf_done_o,
  output logic [AW:0]   buf_len_o,
  input  logic [1:0]    buf_free_i,
  output logic          cur_bank_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(BUF_WORDS - 1);
  localparam logic [AW:0]   FULL_LEN  = (AW+1)'(BUF_WORDS);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          bank_q, bank_d;
  logic [1:0]    full_q, full_d;
  logic [31:0]   pack_q, pack_d;
  logic          rdy_d;
  logic          we_d;
  logic [AW:0]   addr_d;
  logic [31:0]   wdat_d;
  logic [1:0]    done_d;
  logic [AW:0]   len_d;

  logic          accept;
  logic [1:0]    lane;
  logic [31:0]   merged;
  logic [1:0]    full_clr;
  logic [1:0]    set_full;
  logic          close;

  assign accept     = dat_valid_i & dat_ready_o;
  assign cur_bank_o = bank_q;

  // Byte lane for the incoming byte: counter order, or reversed for MSB-first packing.
  assign lane = LSB_FIRST ? bcnt_q : ~bcnt_q;

  // Partial word with the incoming byte dropped into its lane. Lanes not yet
  // written stay 0 because pack_q is cleared whenever a word is emitted.
  always_comb begin
    merged = pack_q;
    merged[{lane, 3'b000} +: 8] = dat_i;
  end

  // Reader releases take effect on the next edge; a release of a bank that is
  // not full is a no-op through the AND.
  assign full_clr = full_q & ~buf_free_i;

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    waddr_d  = waddr_q;
    bank_d   = bank_q;
    pack_d   = pack_q;
    we_d     = 1'b0;
    addr_d   = bram_addr_o;
    wdat_d   = bram_dat_o;
    done_d   = 2'b00;
    len_d    = buf_len_o;
    set_full = 2'b00;
    close    = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {bank_q, waddr_q};
            wdat_d  = merged;
            pack_d  = '0;
            bcnt_d  = 2'd0;
            waddr_d = waddr_q + 1'b1;  // wraps to 0 on the last word
            if (waddr_q == LAST_ADDR) begin
              close = 1'b1;
              len_d = FULL_LEN;
            end
          end else begin
            pack_d = merged;
            bcnt_d = bcnt_q + 2'd1;
          end
        end
        // A fill-close leaves the new bank empty, so a coincident flush has
        // nothing to do; the only question is whether the new bank is free.
        if (close && full_clr[~bank_q]) begin
          state_d = ST_WAIT;
        end else if (flush_i) begin
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (bcnt_q != 2'd0) begin
          we_d   = 1'b1;
          addr_d = {bank_q, waddr_q};
          wdat_d = pack_q;
          len_d  = {1'b0, waddr_q} + 1'b1;
          close  = 1'b1;
        end else if (waddr_q != '0) begin
          len_d = {1'b0, waddr_q};
          close = 1'b1;
        end
        if (close) begin
          waddr_d = '0;
          bcnt_d  = 2'd0;
          pack_d  = '0;
        end
        state_d = (close && full_clr[~bank_q]) ? ST_WAIT : ST_FILL;
      end

      ST_WAIT: begin
        // Using the post-release view lets dat_ready_o return the cycle
        // right after the free strobe.
        if (!full_clr[bank_q]) begin
          state_d = ST_FILL;
        end
      end

      default: state_d = ST_FILL;
    endcase

    if (close) begin
      set_full[bank_q] = 1'b1;
      done_d[bank_q]   = 1'b1;
      bank_d           = ~bank_q;
    end

    // A close of one bank and a release of the other in the same cycle are
    // independent bits, so both take effect.
    full_d = full_clr | set_full;

    // Registered ready: low out of reset, high from the first edge in FILL.
    rdy_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q     <= ST_FILL;
      bcnt_q      <= 2'd0;
      waddr_q     <= '0;
      bank_q      <= 1'b0;
      full_q      <= 2'b00;
      pack_q      <= '0;
      dat_ready_o <= 1'b0;
      bram_we_o   <= 1'b0;
      bram_addr_o <= '0;
      bram_dat_o  <= '0;
      buf_done_o  <= 2'b00;
      buf_len_o   <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      waddr_q     <= waddr_d;
      bank_q      <= bank_d;
      full_q      <= full_d;
      pack_q      <= pack_d;
      dat_ready_o <= rdy_d;
      bram_we_o   <= we_d;
      bram_addr_o <= addr_d;
      bram_dat_o  <= wdat_d;
      buf_done_o  <= done_d;
      buf_len_o   <= len_d;
    end
  end

endmodule

// File: tb/tb_fwupd_bufwr.sv
// Purpose: directed bench for fwupd_bufwr (LSB_FIRST=1, 256-word banks).
// Latency: outputs observed 1ns after the rising edge; BRAM/done activity logged on the falling edge.
// Backpressure: byte sends wait on dat_ready_o with a bounded cycle budget.
`timescale 1ns/1ps

module tb_fwupd_bufwr;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstb_i;
  logic [7:0]    dat_i;
  logic          dat_valid_i;
  logic          dat_ready_o;
  logic          flush_i;
  logic          bram_we_o;
  logic [AW:0]   bram_addr_o;
  logic [31:0]   bram_dat_o;
  logic [1:0]    buf_done_o;
  logic [AW:0]   buf_len_o;
  logic [1:0]    buf_free_i;
  logic          cur_bank_o;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [AW:0] wq_addr[$];
  logic [31:0] wq_dat[$];
  int          wq_cyc[$];
  logic [1:0]  dq_mask[$];
  logic [AW:0] dq_len[$];
  int          dq_cyc[$];

  fwupd_bufwr #(.BUF_WORDS(256), .LSB_FIRST(1'b1)) dut (
    .clk_i       (clk),
    .rstb_i      (rstb_i),
    .dat_i       (dat_i),
    .dat_valid_i (dat_valid_i),
    .dat_ready_o (dat_ready_o),
    .flush_i     (flush_i),
    .bram_we_o   (bram_we_o),
    .bram_addr_o (bram_addr_o),
    .bram_dat_o  (bram_dat_o),
    .buf_done_o  (buf_done_o),
    .buf_len_o   (buf_len_o),
    .buf_free_i  (buf_free_i),
    .cur_bank_o  (cur_bank_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_we_o) begin
      wq_addr.push_back(bram_addr_o);
      wq_dat.push_back(bram_dat_o);
      wq_cyc.push_back(cyc);
    end
    if (buf_done_o != 2'b00) begin
      dq_mask.push_back(buf_done_o);
      dq_len.push_back(buf_len_o);
      dq_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    wq_addr.delete(); wq_dat.delete(); wq_cyc.delete();
    dq_mask.delete(); dq_len.delete(); dq_cyc.delete();
  endtask

  task automatic idle(input int n);
    dat_valid_i = 1'b0;
    flush_i     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    dat_i = b;
    dat_valid_i = 1'b1;
    n = 0;
    while (!dat_ready_o && n < 500) begin
      tick();
      n++;
    end
    vecs++;
    if (!dat_ready_o) begin
      errs++;
      $display("FAIL send_timeout byte=%02h ready=%0b required=1", b, dat_ready_o);
    end
    tick();
  endtask

  task automatic do_reset();
    rstb_i = 1'b0; dat_valid_i = 1'b0; flush_i = 1'b0; buf_free_i = 2'b00; dat_i = 8'h00;
    repeat (2) tick();
    rstb_i = 1'b1;
    tick();
    clr_q();
  endtask

  task automatic test_reset();
    rstb_i = 1'b0; dat_valid_i = 1'b0; flush_i = 1'b0; buf_free_i = 2'b00; dat_i = 8'h00;
    tick();
    vecs++; if (bram_we_o !== 1'b0)   begin errs++; $display("FAIL rst_we got=%0b exp=0", bram_we_o); end
    vecs++; if (bram_addr_o !== 9'h0) begin errs++; $display("FAIL rst_addr got=%h exp=000", bram_addr_o); end
    vecs++; if (bram_dat_o !== 32'h0) begin errs++; $display("FAIL rst_dat got=%h exp=0", bram_dat_o); end
    vecs++; if (buf_done_o !== 2'b00) begin errs++; $display("FAIL rst_done got=%b exp=00", buf_done_o); end
    vecs++; if (buf_len_o !== 9'h0)   begin errs++; $display("FAIL rst_len got=%h exp=000", buf_len_o); end
    vecs++; if (cur_bank_o !== 1'b0)  begin errs++; $display("FAIL rst_bank got=%0b exp=0", cur_bank_o); end
    vecs++; if (dat_ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready got=%0b exp=0", dat_ready_o); end
    rstb_i = 1'b1;
    #2;
    vecs++; if (dat_ready_o !== 1'b0) begin errs++; $display("FAIL rel_ready_early got=%0b exp=0", dat_ready_o); end
    tick();
    vecs++; if (dat_ready_o !== 1'b1) begin errs++; $display("FAIL rel_ready_edge got=%0b exp=1", dat_ready_o); end
  endtask

  task automatic test_single_word();
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    vecs++; if (wq_addr.size() != 1) begin errs++; $display("FAIL single_count got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      vecs++; if (wq_addr[0] !== 9'h000)     begin errs++; $display("FAIL single_addr got=%h exp=000", wq_addr[0]); end
      vecs++; if (wq_dat[0] !== 32'h44332211) begin errs++; $display("FAIL single_dat got=%h exp=44332211", wq_dat[0]); end
    end
    vecs++; if (dq_mask.size() != 0) begin errs++; $display("FAIL single_done got=%0d exp=0", dq_mask.size()); end
    vecs++; if (dat_ready_o !== 1'b1) begin errs++; $display("FAIL single_ready got=%0b exp=1", dat_ready_o); end
  endtask

  task automatic test_full_bank();
    logic [31:0] exp_w;
    do_reset();
    for (int i = 0; i < 1024; i++) send_byte(8'(i));
    idle(3);
    vecs++; if (wq_addr.size() != 256) begin errs++; $display("FAIL full_count got=%0d exp=256", wq_addr.size()); end
    for (int k = 0; k < 256; k++) begin
      if (wq_addr.size() > k) begin
        exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        vecs++; if (wq_addr[k] !== 9'(k)) begin errs++; $display("FAIL full_addr[%0d] got=%h exp=%h", k, wq_addr[k], 9'(k)); end
        vecs++; if (wq_dat[k] !== exp_w)  begin errs++; $display("FAIL full_dat[%0d] got=%h exp=%h", k, wq_dat[k], exp_w); end
      end
    end
    vecs++; if (dq_mask.size() != 1) begin errs++; $display("FAIL full_done_count got=%0d exp=1", dq_mask.size()); end
    if (dq_mask.size() >= 1 && wq_cyc.size() == 256) begin
      vecs++; if (dq_mask[0] !== 2'b01)  begin errs++; $display("FAIL full_done_mask got=%b exp=01", dq_mask[0]); end
      vecs++; if (dq_len[0] !== 9'h100)  begin errs++; $display("FAIL full_len got=%h exp=100", dq_len[0]); end
      vecs++; if (dq_cyc[0] != wq_cyc[255]) begin errs++; $display("FAIL full_done_cycle got=%0d exp=%0d", dq_cyc[0], wq_cyc[255]); end
    end
    vecs++; if (cur_bank_o !== 1'b1)  begin errs++; $display("FAIL full_bank got=%0b exp=1", cur_bank_o); end
    vecs++; if (dat_ready_o !== 1'b1) begin errs++; $display("FAIL full_ready got=%0b exp=1", dat_ready_o); end
    clr_q();
    send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C); send_byte(8'h5D);
    idle(2);
    vecs++; if (wq_addr.size() != 1) begin errs++; $display("FAIL next_count got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      vecs++; if (wq_addr[0] !== 9'h100)     begin errs++; $display("FAIL next_addr got=%h exp=100", wq_addr[0]); end
      vecs++; if (wq_dat[0] !== 32'h5D5C5B5A) begin errs++; $display("FAIL next_dat got=%h exp=5D5C5B5A", wq_dat[0]); end
    end
  endtask

  // Continues from test_full_bank: bank 0 full, bank 1 holds one word.
  task automatic test_wait();
    clr_q();
    for (int i = 0; i < 1020; i++) send_byte(8'(i));
    idle(3);
    vecs++; if (wq_addr.size() != 255) begin errs++; $display("FAIL wait_count got=%0d exp=255", wq_addr.size()); end
    if (wq_addr.size() == 255) begin
      vecs++; if (wq_addr[254] !== 9'h1FF) begin errs++; $display("FAIL wait_last_addr got=%h exp=1FF", wq_addr[254]); end
    end
    vecs++; if (dq_mask.size() != 1) begin errs++; $display("FAIL wait_done_count got=%0d exp=1", dq_mask.size()); end
    if (dq_mask.size() >= 1) begin
      vecs++; if (dq_mask[0] !== 2'b10) begin errs++; $display("FAIL wait_done_mask got=%b exp=10", dq_mask[0]); end
      vecs++; if (dq_len[0] !== 9'h100) begin errs++; $display("FAIL wait_len got=%h exp=100", dq_len[0]); end
    end
    vecs++; if (dat_ready_o !== 1'b0) begin errs++; $display("FAIL wait_ready got=%0b exp=0", dat_ready_o); end
    vecs++; if (cur_bank_o !== 1'b0)  begin errs++; $display("FAIL wait_bank got=%0b exp=0", cur_bank_o); end
    clr_q();
    dat_i = 8'hEE; dat_valid_i = 1'b1;
    repeat (5) tick();
    vecs++; if (wq_addr.size() != 0)  begin errs++; $display("FAIL wait_hold_writes got=%0d exp=0", wq_addr.size()); end
    vecs++; if (dat_ready_o !== 1'b0) begin errs++; $display("FAIL wait_hold_ready got=%0b exp=0", dat_ready_o); end
    buf_free_i = 2'b01;
    tick();
    buf_free_i = 2'b00;
    vecs++; if (dat_ready_o !== 1'b1) begin errs++; $display("FAIL free_ready got=%0b exp=1", dat_ready_o); end
    send_byte(8'hEE); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(2);
    vecs++; if (wq_addr.size() != 1) begin errs++; $display("FAIL free_count got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      vecs++; if (wq_addr[0] !== 9'h000)     begin errs++; $display("FAIL free_addr got=%h exp=000", wq_addr[0]); end
      vecs++; if (wq_dat[0] !== 32'h030201EE) begin errs++; $display("FAIL free_dat got=%h exp=030201EE", wq_dat[0]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    idle(2);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    vecs++; if (dat_ready_o !== 1'b0) begin errs++; $display("FAIL flush_ready_low got=%0b exp=0", dat_ready_o); end
    tick();
    vecs++; if (dat_ready_o !== 1'b1) begin errs++; $display("FAIL flush_ready_back got=%0b exp=1", dat_ready_o); end
    idle(3);
    vecs++; if (wq_addr.size() != 2) begin errs++; $display("FAIL flush_count got=%0d exp=2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      vecs++; if (wq_dat[0] !== 32'h04030201) begin errs++; $display("FAIL flush_dat0 got=%h exp=04030201", wq_dat[0]); end
      vecs++; if (wq_addr[1] !== 9'h001)      begin errs++; $display("FAIL flush_addr1 got=%h exp=001", wq_addr[1]); end
      vecs++; if (wq_dat[1] !== 32'h00000605) begin errs++; $display("FAIL flush_dat1 got=%h exp=00000605", wq_dat[1]); end
    end
    vecs++; if (dq_mask.size() != 1) begin errs++; $display("FAIL flush_done_count got=%0d exp=1", dq_mask.size()); end
    if (dq_mask.size() == 1 && wq_cyc.size() == 2) begin
      vecs++; if (dq_mask[0] !== 2'b01) begin errs++; $display("FAIL flush_mask got=%b exp=01", dq_mask[0]); end
      vecs++; if (dq_len[0] !== 9'd2)   begin errs++; $display("FAIL flush_len got=%0d exp=2", dq_len[0]); end
      vecs++; if (dq_cyc[0] != wq_cyc[1]) begin errs++; $display("FAIL flush_done_cycle got=%0d exp=%0d", dq_cyc[0], wq_cyc[1]); end
    end
    vecs++; if (cur_bank_o !== 1'b1) begin errs++; $display("FAIL flush_bank got=%0b exp=1", cur_bank_o); end
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    flush_i = 1'b1;
    send_byte(8'h05);
    flush_i = 1'b0;
    idle(4);
    vecs++; if (wq_addr.size() != 2) begin errs++; $display("FAIL fsame_count got=%0d exp=2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      vecs++; if (wq_addr[1] !== 9'h001)      begin errs++; $display("FAIL fsame_addr got=%h exp=001", wq_addr[1]); end
      vecs++; if (wq_dat[1] !== 32'h00000005) begin errs++; $display("FAIL fsame_dat got=%h exp=00000005", wq_dat[1]); end
    end
    vecs++; if (dq_len.size() != 1) begin errs++; $display("FAIL fsame_done_count got=%0d exp=1", dq_len.size()); end
    if (dq_len.size() == 1) begin
      vecs++; if (dq_len[0] !== 9'd2) begin errs++; $display("FAIL fsame_len got=%0d exp=2", dq_len[0]); end
    end
  endtask

  task automatic test_flush_empty();
    do_reset();
    flush_i = 1'b1;
    tick();
    idle(4);
    vecs++; if (wq_addr.size() != 0)  begin errs++; $display("FAIL fempty_writes got=%0d exp=0", wq_addr.size()); end
    vecs++; if (dq_mask.size() != 0)  begin errs++; $display("FAIL fempty_done got=%0d exp=0", dq_mask.size()); end
    vecs++; if (cur_bank_o !== 1'b0)  begin errs++; $display("FAIL fempty_bank got=%0b exp=0", cur_bank_o); end
    vecs++; if (dat_ready_o !== 1'b1) begin errs++; $display("FAIL fempty_ready got=%0b exp=1", dat_ready_o); end
    for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
    idle(2);
    flush_i = 1'b1;
    tick();
    idle(4);
    vecs++; if (wq_addr.size() != 3) begin errs++; $display("FAIL fword_writes got=%0d exp=3", wq_addr.size()); end
    vecs++; if (dq_mask.size() != 1) begin errs++; $display("FAIL fword_done got=%0d exp=1", dq_mask.size()); end
    if (dq_mask.size() == 1) begin
      vecs++; if (dq_mask[0] !== 2'b01) begin errs++; $display("FAIL fword_mask got=%b exp=01", dq_mask[0]); end
      vecs++; if (dq_len[0] !== 9'd3)   begin errs++; $display("FAIL fword_len got=%0d exp=3", dq_len[0]); end
    end
    vecs++; if (cur_bank_o !== 1'b1) begin errs++; $display("FAIL fword_bank got=%0b exp=1", cur_bank_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    send_byte(8'hB0); send_byte(8'hB1);
    idle(1);
    vecs++; if (bram_dat_o !== 32'hA7A6A5A4) begin errs++; $display("FAIL rmid_pre_dat got=%h exp=A7A6A5A4", bram_dat_o); end
    vecs++; if (bram_addr_o !== 9'h001)      begin errs++; $display("FAIL rmid_pre_addr got=%h exp=001", bram_addr_o); end
    #3;
    rstb_i = 1'b0;
    #1;
    vecs++; if (bram_dat_o !== 32'h0)  begin errs++; $display("FAIL rmid_dat got=%h exp=0", bram_dat_o); end
    vecs++; if (bram_addr_o !== 9'h0)  begin errs++; $display("FAIL rmid_addr got=%h exp=000", bram_addr_o); end
    vecs++; if (dat_ready_o !== 1'b0)  begin errs++; $display("FAIL rmid_ready got=%0b exp=0", dat_ready_o); end
    vecs++; if (bram_we_o !== 1'b0)    begin errs++; $display("FAIL rmid_we got=%0b exp=0", bram_we_o); end
    tick();
    rstb_i = 1'b1;
    tick();
    clr_q();
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    idle(3);
    vecs++; if (wq_addr.size() != 1) begin errs++; $display("FAIL rmid_count got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      vecs++; if (wq_addr[0] !== 9'h000)     begin errs++; $display("FAIL rmid_waddr got=%h exp=000", wq_addr[0]); end
      vecs++; if (wq_dat[0] !== 32'hC4C3C2C1) begin errs++; $display("FAIL rmid_wdat got=%h exp=C4C3C2C1", wq_dat[0]); end
    end
    vecs++; if (dq_mask.size() != 0) begin errs++; $display("FAIL rmid_done got=%0d exp=0", dq_mask.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end

  initial begin
    rstb_i = 1'b0; dat_valid_i = 1'b0; flush_i = 1'b0; buf_free_i = 2'b00; dat_i = 8'h00;
    test_reset();
    test_single_word();
    test_full_bank();
    test_wait();
    test_flush();
    test_flush_same_cycle();
    test_flush_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
